multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control unit. Sequences each instruction through fetch/decode/execute/memory/writeback states and issues per-state datapath controls. Waits on a memory-ready handshake with a bounded timeout. Parametrised in ALUOp width and memory wait bound. Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

---
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS controller sequencing fetch/decode/execute/memory/writeback.
// Inputs:  clk, reset (async active-low), run (start from IDLE), op (opcode, read in DECODE),
//          mem_ready (memory access completes this cycle).
// Outputs: per-state datapath controls (pc_write*, iord, mem_*, ir_write, reg_*, alu_*, pc_source),
//          sticky illegal_op / timeout flags, and the current state for debug.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_eq,
  output logic                   pc_write_ne,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic [1:0]             reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   illegal_op,
  output logic                   timeout,
  output logic [3:0]             state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, EXEC_R = 4'd7, R_WB = 4'd8, EXEC_I = 4'd9,
    I_WB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12, JAL = 4'd13, TRAP = 4'd15
  } state_t;
  localparam int CW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND = ALUOP_WIDTH'(3'b110);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = ALUOP_WIDTH'(3'b011);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI = ALUOP_WIDTH'(3'b010);
  localparam logic [ALUOP_WIDTH-1:0] ALU_R   = ALUOP_WIDTH'(3'b111);
  state_t stateQ, nextState;
  logic [CW-1:0] waitCnt;
  logic [5:0] opQ;
  logic isWait, setIllegal, setTimeout;
  assign state = stateQ;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      waitCnt <= '0;
      opQ <= '0;
      illegal_op <= 1'b0;
      timeout <= 1'b0;
    end else begin
      stateQ <= nextState;
      // counter restarts whenever a wait state is (re)entered; it only runs while stalled in place
      waitCnt <= (isWait && nextState == stateQ) ? waitCnt + 1'b1 : '0;
      if (stateQ == DECODE) opQ <= op;
      illegal_op <= illegal_op | setIllegal;
      timeout <= timeout | setTimeout;
    end
  end
  always_comb begin
    nextState = stateQ;
    setIllegal = 1'b0;
    setTimeout = 1'b0;
    isWait = stateQ inside {FETCH, MEM_READ, MEM_WRITE};
    pc_write = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 2'b00;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_source = 2'b00;
    alu_op = '0;
    case (stateQ)
      IDLE: nextState = run ? FETCH : IDLE;
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        alu_op = ALU_ADD;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op = ALU_ADD;
        case (op)
          6'h00: nextState = EXEC_R;
          6'h08, 6'h0d, 6'h0c, 6'h0f: nextState = EXEC_I;
          6'h23, 6'h2b: nextState = MEM_ADDR;
          6'h04, 6'h05: nextState = BRANCH;
          6'h02: nextState = JUMP;
          6'h03: nextState = JAL;
          default: begin
            nextState = TRAP;
            setIllegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = ALU_ADD;
        nextState = opQ == 6'h23 ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord = 1'b1;
        nextState = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        nextState = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord = 1'b1;
        nextState = mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = ALU_R;
        nextState = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst = 2'b01;
        nextState = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = opQ == 6'h0d ? ALU_OR : opQ == 6'h0c ? ALU_AND : opQ == 6'h0f ? ALU_LUI : ALU_ADD;
        nextState = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_source = 2'b01;
        pc_write_eq = opQ == 6'h04;
        pc_write_ne = opQ == 6'h05;
        nextState = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        nextState = FETCH;
      end
      JAL: begin
        pc_write = 1'b1;
        pc_source = 2'b10;
        reg_write = 1'b1;
        reg_dst = 2'b10;
        nextState = FETCH;
      end
      TRAP: nextState = TRAP;
      default: nextState = IDLE;
    endcase
    // a ready in the last allowed cycle still completes normally
    if (isWait && !mem_ready && waitCnt == CW'(MAX_WAIT - 1)) begin
      nextState = TRAP;
      setTimeout = 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench for multicycle_control.
module tb_multicycle_control;
  localparam int W = 4;
  localparam int MW = 4;
  logic clk = 0, reset = 1, run = 0, mem_ready = 0;
  logic [5:0] op = 0;
  logic pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic reg_write, alu_src_a, illegal_op, timeout;
  logic [1:0] reg_dst, alu_src_b, pc_source;
  logic [W-1:0] alu_op;
  logic [3:0] state;
  logic [15+W:0] obs;
  int checks = 0, failures = 0;
  logic [5:0] legal [11] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
  always #5 clk = ~clk;
  multicycle_control #(.ALUOP_WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .illegal_op(illegal_op), .timeout(timeout), .state(state)
  );
  assign obs = {pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};
  // Expected controls per state, taken straight from the control table
  function automatic logic [15+W:0] expCtl(int st, logic [5:0] o, logic rdy);
    logic pw, eq, ne, io, mr, mwr, irw, m2r, rw, sa;
    logic [1:0] rd, sb, ps;
    logic [W-1:0] ao;
    {pw, eq, ne, io, mr, mwr, irw, m2r, rw, sa} = '0;
    {rd, sb, ps} = '0;
    ao = '0;
    case (st)
      1: begin mr = 1; sb = 1; ao = 4; irw = rdy; pw = rdy; end
      2: begin sb = 3; ao = 4; end
      3: begin sa = 1; sb = 2; ao = 4; end
      4: begin mr = 1; io = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mwr = 1; io = 1; end
      7: begin sa = 1; ao = 7; end
      8: begin rw = 1; rd = 1; end
      9: begin sa = 1; sb = 2; ao = o == 6'h0d ? 5 : o == 6'h0c ? 6 : o == 6'h0f ? 2 : 4; end
      10: rw = 1;
      11: begin sa = 1; ao = 3; ps = 1; eq = o == 6'h04; ne = o == 6'h05; end
      12: begin pw = 1; ps = 2; end
      13: begin pw = 1; ps = 2; rw = 1; rd = 2; end
      default: ;
    endcase
    return {pw, eq, ne, io, mr, mwr, irw, m2r, rd, rw, sa, sb, ps, ao};
  endfunction
  // Reset then start; returns at a falling edge with the controller in FETCH
  task automatic startRun();
    @(negedge clk);
    reset = 0;
    run = 0;
    mem_ready = 0;
    #1 reset = 1;
    @(negedge clk) run = 1;
    @(negedge clk) run = 1'($urandom);
  endtask
  task automatic test_reset();
    #2 reset = 0;
    run = 1;
    mem_ready = 1;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== '0 || illegal_op !== 0 || timeout !== 0) begin
      failures++;
      $display("FAIL reset_async: state=%0d ctl=%h ill=%b to=%b want 0/0/0/0", state, obs, illegal_op, timeout);
    end
    @(posedge clk) #1;
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_hold: state=%0d want 0", state); end
    @(negedge clk) reset = 1;
    run = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 4'd0 || obs !== '0) begin failures++; $display("FAIL idle_no_run: state=%0d ctl=%h want 0", state, obs); end
  endtask
  task automatic test_random();
    startRun();
    for (int k = 0; k < 40; k++) begin
      int sts[$];
      logic rdys[$];
      logic [5:0] o;
      int s;
      o = legal[$urandom_range(0, 10)];
      s = $urandom_range(0, MW - 1);
      repeat (s) begin sts.push_back(1); rdys.push_back(0); end
      sts.push_back(1); rdys.push_back(1);
      sts.push_back(2); rdys.push_back(1'($urandom));
      case (o)
        6'h00: begin sts.push_back(7); sts.push_back(8); end
        6'h08, 6'h0d, 6'h0c, 6'h0f: begin sts.push_back(9); sts.push_back(10); end
        6'h23, 6'h2b: begin
          sts.push_back(3);
          s = $urandom_range(0, MW - 1);
          repeat (s) begin sts.push_back(o == 6'h23 ? 4 : 6); end
          sts.push_back(o == 6'h23 ? 4 : 6);
          if (o == 6'h23) sts.push_back(5);
        end
        6'h04, 6'h05: sts.push_back(11);
        6'h02: sts.push_back(12);
        default: sts.push_back(13);
      endcase
      // ready pattern for the post-decode part: stall s cycles in the memory state, then complete
      for (int i = rdys.size(); i < sts.size(); i++) begin
        if (sts[i] == 4 || sts[i] == 6) rdys.push_back((i + 1 < sts.size() && sts[i + 1] == sts[i]) ? 1'b0 : 1'b1);
        else rdys.push_back(1'($urandom));
      end
      for (int i = 0; i < sts.size(); i++) begin
        mem_ready = rdys[i];
        op = sts[i] == 2 ? o : 6'($urandom);
        run = 1'($urandom);
        #1;
        checks++;
        if (state !== 4'(sts[i]) || obs !== expCtl(sts[i], o, rdys[i]) || illegal_op !== 0 || timeout !== 0) begin
          failures++;
          $display("FAIL instr op=%h step %0d: state=%0d ctl=%h flags=%b%b want state=%0d ctl=%h flags=00",
                   o, i, state, obs, illegal_op, timeout, sts[i], expCtl(sts[i], o, rdys[i]));
        end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_illegal();
    for (int t = 0; t < 4; t++) begin
      logic [5:0] bad;
      bad = 6'h3f;
      if (t > 0) begin
        bad = 6'($urandom);
        while (bad inside {6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03}) bad = 6'($urandom);
      end
      startRun();
      mem_ready = 1;
      @(negedge clk) op = bad;
      #1;
      checks++;
      if (state !== 4'd2) begin failures++; $display("FAIL illegal_decode: state=%0d want 2", state); end
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        run = ~run;
        mem_ready = 1'($urandom);
        op = 6'($urandom);
        #1;
        checks++;
        if (state !== 4'd15 || obs !== '0 || illegal_op !== 1 || timeout !== 0) begin
          failures++;
          $display("FAIL illegal_trap op=%h c=%0d: state=%0d ctl=%h ill=%b to=%b want 15/0/1/0", bad, c, state, obs, illegal_op, timeout);
        end
        @(negedge clk);
      end
      reset = 0;
      #1;
      checks++;
      if (state !== 4'd0 || illegal_op !== 0) begin failures++; $display("FAIL illegal_reset: state=%0d ill=%b want 0/0", state, illegal_op); end
      reset = 1;
    end
  endtask
  task automatic test_timeout();
    startRun();
    for (int i = 0; i < MW; i++) begin
      mem_ready = 0;
      #1;
      checks++;
      if (state !== 4'd1 || obs !== expCtl(1, 0, 0)) begin failures++; $display("FAIL fetch_stall %0d: state=%0d ctl=%h want 1", i, state, obs); end
      @(negedge clk);
    end
    checks++;
    if (state !== 4'd15 || timeout !== 1 || illegal_op !== 0 || obs !== '0) begin
      failures++;
      $display("FAIL fetch_timeout: state=%0d to=%b ill=%b ctl=%h want 15/1/0/0", state, timeout, illegal_op, obs);
    end
    startRun();
    checks++;
    if (timeout !== 0) begin failures++; $display("FAIL timeout_clear: to=%b want 0", timeout); end
    for (int i = 0; i < MW; i++) begin
      mem_ready = i == MW - 1;
      #1 @(negedge clk);
    end
    checks++;
    if (state !== 4'd2 || timeout !== 0) begin failures++; $display("FAIL fetch_last_ready: state=%0d to=%b want 2/0", state, timeout); end
    startRun();
    mem_ready = 1;
    @(negedge clk) op = 6'h2b;
    @(negedge clk) op = 6'h23;
    @(negedge clk) mem_ready = 0;
    for (int i = 0; i < MW; i++) begin
      #1;
      checks++;
      if (state !== 4'd6) begin failures++; $display("FAIL write_stall %0d: state=%0d want 6", i, state); end
      @(negedge clk);
    end
    checks++;
    if (state !== 4'd15 || timeout !== 1) begin failures++; $display("FAIL write_timeout: state=%0d to=%b want 15/1", state, timeout); end
  endtask
  task automatic test_reset_midwait();
    startRun();
    mem_ready = 1;
    @(negedge clk) op = 6'h23;
    @(negedge clk);
    @(negedge clk) mem_ready = 0;
    @(negedge clk);
    #3;
    checks++;
    if (state !== 4'd4 || mem_read !== 1) begin failures++; $display("FAIL read_wait: state=%0d rd=%b want 4/1", state, mem_read); end
    reset = 0;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== '0) begin failures++; $display("FAIL reset_midwait: state=%0d ctl=%h want 0/0", state, obs); end
    reset = 1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
